// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and constants for the ALU issue sequencer
//
// Holds the sequencer state enum, datapath and register-index widths,
// and the named ALU function-select codes used by the sequencer.
package alu_seq_pkg;

  localparam int DATA_W    = 16;
  localparam int NUM_REGS  = 8;
  localparam int REG_IDX_W = 3;
  localparam int FUNSEL_W  = 5;
  localparam int FLAGS_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } seq_state_e;

  // FunSel[4] selects a full-width result; clear means only the low byte is kept.
  localparam logic [FUNSEL_W-1:0] FS_PASS_A_8  = 5'b00000;
  localparam logic [FUNSEL_W-1:0] FS_PASS_A_16 = 5'b10000;
  localparam logic [FUNSEL_W-1:0] FS_ADD_16    = 5'b10100;
  localparam logic [FUNSEL_W-1:0] FS_SUB_16    = 5'b10110;

  function automatic logic is_wide_op(input logic [FUNSEL_W-1:0] fs);
    return fs[FUNSEL_W-1];
  endfunction

endpackage

// File: rtl/seq_regfile.sv
// rtl/seq_regfile.sv - operand register file for the ALU issue sequencer
//
// NUM_REGS x DATA_W registers, cleared by reset.
// Ports:
//   Clock, Reset          - system clock, async active-low reset
//   rd_sel_a/b, rd_data_a/b - two combinational operand read ports
//   dbg_sel, dbg_data     - combinational debug read port
//   wb_en/sel/data        - writeback port (wins on an index collision)
//   load_en/sel/data      - direct load port
module seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int DATA_W   = alu_seq_pkg::DATA_W,
  parameter int NUM_REGS = alu_seq_pkg::NUM_REGS
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [REG_IDX_W-1:0] rd_sel_a,
  input  logic [REG_IDX_W-1:0] rd_sel_b,
  output logic [DATA_W-1:0]    rd_data_a,
  output logic [DATA_W-1:0]    rd_data_b,
  input  logic [REG_IDX_W-1:0] dbg_sel,
  output logic [DATA_W-1:0]    dbg_data,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_sel,
  input  logic [DATA_W-1:0]    wb_data,
  input  logic                 load_en,
  input  logic [REG_IDX_W-1:0] load_sel,
  input  logic [DATA_W-1:0]    load_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // A load is suppressed only when it collides with a writeback to the same register.
  logic load_blocked;
  assign load_blocked = wb_en && (load_sel == wb_sel);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wb_en) begin
        regs[wb_sel] <= wb_data;
      end
      if (load_en && !load_blocked) begin
        regs[load_sel] <= load_data;
      end
    end
  end

  assign rd_data_a = regs[rd_sel_a];
  assign rd_data_b = regs[rd_sel_b];
  assign dbg_data  = regs[dbg_sel];

endmodule

// File: rtl/alu_issue_sequencer.sv
// rtl/alu_issue_sequencer.sv - fixed-latency issue sequencer for an external ALU
//
// Accepts one request per 4 cycles (IDLE -> DRIVE -> CAPTURE -> DONE), drives
// snapshot operands and function select to the ALU, writes the result back to
// the register file and pulses DoneValid.
// Ports:
//   Clock, Reset                   - system clock, async active-low reset
//   ReqValid/ReqReady              - request handshake
//   ReqFunSel/ReqSrcA/ReqSrcB/ReqDst/ReqWF - request fields
//   A, B, FunSel, WF               - ALU drive
//   ALUOut, FlagsIn                - ALU result and flags {Z,C,N,O}
//   DoneValid/DoneResult/DoneFlags - completion pulse and captured values
//   LoadEn/LoadSel/LoadData        - direct register write
//   DbgSel/DbgData                 - combinational register read
module alu_issue_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W   = alu_seq_pkg::DATA_W,
  parameter int NUM_REGS = alu_seq_pkg::NUM_REGS
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 ReqValid,
  output logic                 ReqReady,
  input  logic [FUNSEL_W-1:0]  ReqFunSel,
  input  logic [REG_IDX_W-1:0] ReqSrcA,
  input  logic [REG_IDX_W-1:0] ReqSrcB,
  input  logic [REG_IDX_W-1:0] ReqDst,
  input  logic                 ReqWF,
  output logic [DATA_W-1:0]    A,
  output logic [DATA_W-1:0]    B,
  output logic [FUNSEL_W-1:0]  FunSel,
  output logic                 WF,
  input  logic [DATA_W-1:0]    ALUOut,
  input  logic [FLAGS_W-1:0]   FlagsIn,
  output logic                 DoneValid,
  output logic [DATA_W-1:0]    DoneResult,
  output logic [FLAGS_W-1:0]   DoneFlags,
  input  logic                 LoadEn,
  input  logic [REG_IDX_W-1:0] LoadSel,
  input  logic [DATA_W-1:0]    LoadData,
  input  logic [REG_IDX_W-1:0] DbgSel,
  output logic [DATA_W-1:0]    DbgData
);

  seq_state_e            state_q, state_d;
  logic [REG_IDX_W-1:0]  dst_q;
  logic [DATA_W-1:0]     rd_data_a, rd_data_b;
  logic [DATA_W-1:0]     wb_data;
  logic                  wb_en;
  logic                  handshake;

  assign ReqReady  = (state_q == ST_IDLE);
  assign DoneValid = (state_q == ST_DONE);
  assign handshake = ReqValid && ReqReady;
  assign wb_en     = (state_q == ST_CAPTURE);

  // Narrow operations keep only the low byte of the ALU result.
  assign wb_data = is_wide_op(FunSel) ? ALUOut
                                      : {{(DATA_W-8){1'b0}}, ALUOut[7:0]};

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (handshake) state_d = ST_DRIVE;
      ST_DRIVE:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Operands are snapshotted at the handshake so later loads or the writeback
  // itself cannot disturb an operation already in flight.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      A          <= '0;
      B          <= '0;
      FunSel     <= FS_PASS_A_16;
      WF         <= 1'b0;
      dst_q      <= '0;
      DoneResult <= '0;
      DoneFlags  <= '0;
    end else begin
      if (handshake) begin
        A      <= rd_data_a;
        B      <= rd_data_b;
        FunSel <= ReqFunSel;
        WF     <= ReqWF;
        dst_q  <= ReqDst;
      end
      if (wb_en) begin
        WF         <= 1'b0;
        DoneResult <= wb_data;
        DoneFlags  <= FlagsIn;
      end
    end
  end

  seq_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .Clock     (Clock),
    .Reset     (Reset),
    .rd_sel_a  (ReqSrcA),
    .rd_sel_b  (ReqSrcB),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .dbg_sel   (DbgSel),
    .dbg_data  (DbgData),
    .wb_en     (wb_en),
    .wb_sel    (dst_q),
    .wb_data   (wb_data),
    .load_en   (LoadEn),
    .load_sel  (LoadSel),
    .load_data (LoadData)
  );

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// tb/tb_alu_issue_sequencer.sv - directed self-checking bench for alu_issue_sequencer
module tb_alu_issue_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        ReqValid;
  logic        ReqReady;
  logic [4:0]  ReqFunSel;
  logic [2:0]  ReqSrcA, ReqSrcB, ReqDst;
  logic        ReqWF;
  logic [15:0] A, B;
  logic [4:0]  FunSel;
  logic        WF;
  logic [15:0] ALUOut;
  logic [3:0]  FlagsIn;
  logic        DoneValid;
  logic [15:0] DoneResult;
  logic [3:0]  DoneFlags;
  logic        LoadEn;
  logic [2:0]  LoadSel;
  logic [15:0] LoadData;
  logic [2:0]  DbgSel;
  logic [15:0] DbgData;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clock = ~Clock;

  alu_issue_sequencer dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .ReqValid   (ReqValid),
    .ReqReady   (ReqReady),
    .ReqFunSel  (ReqFunSel),
    .ReqSrcA    (ReqSrcA),
    .ReqSrcB    (ReqSrcB),
    .ReqDst     (ReqDst),
    .ReqWF      (ReqWF),
    .A          (A),
    .B          (B),
    .FunSel     (FunSel),
    .WF         (WF),
    .ALUOut     (ALUOut),
    .FlagsIn    (FlagsIn),
    .DoneValid  (DoneValid),
    .DoneResult (DoneResult),
    .DoneFlags  (DoneFlags),
    .LoadEn     (LoadEn),
    .LoadSel    (LoadSel),
    .LoadData   (LoadData),
    .DbgSel     (DbgSel),
    .DbgData    (DbgData)
  );

  // Small ALU stand-in: combinational result, flag register written when WF is high.
  logic [16:0] alu_t;
  logic [3:0]  alu_flags;
  logic        f_z, f_c, f_n, f_o;
  always_comb begin
    alu_t = {1'b0, A};
    f_c   = 1'b0;
    f_o   = 1'b0;
    case (FunSel)
      5'b10100: begin
        alu_t = {1'b0, A} + {1'b0, B};
        f_c   = alu_t[16];
        f_o   = (A[15] == B[15]) && (alu_t[15] != A[15]);
      end
      5'b10110: begin
        alu_t = {1'b0, A} - {1'b0, B};
        f_c   = (A >= B);
        f_o   = (A[15] != B[15]) && (alu_t[15] != A[15]);
      end
      default: alu_t = {1'b0, A};
    endcase
    f_n       = FunSel[4] ? alu_t[15] : alu_t[7];
    f_z       = FunSel[4] ? (alu_t[15:0] == 16'h0) : (alu_t[7:0] == 8'h0);
    alu_flags = {f_z, f_c, f_n, f_o};
    ALUOut    = alu_t[15:0];
  end

  always @(posedge Clock or negedge Reset) begin
    if (!Reset)  FlagsIn <= 4'h0;
    else if (WF) FlagsIn <= alu_flags;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic load_reg(input logic [2:0] idx, input logic [15:0] data);
    LoadEn   = 1'b1;
    LoadSel  = idx;
    LoadData = data;
    tick();
    LoadEn   = 1'b0;
  endtask

  task automatic read_reg(input logic [2:0] idx, output logic [15:0] data);
    DbgSel = idx;
    #1;
    data = DbgData;
  endtask

  // Presents a request in IDLE and returns just after the accepting edge (state DRIVE).
  task automatic issue(input logic [4:0] fs, input logic [2:0] sa, input logic [2:0] sb,
                       input logic [2:0] dst, input logic wf);
    ReqFunSel = fs;
    ReqSrcA   = sa;
    ReqSrcB   = sb;
    ReqDst    = dst;
    ReqWF     = wf;
    ReqValid  = 1'b1;
    check("ready_before_issue", ReqReady, 1'b1);
    tick();
    ReqValid  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  logic [15:0] rv;
  int          hs_cyc[$];
  int          n_done;

  initial begin
    Reset = 1'b0; ReqValid = 1'b0; ReqFunSel = '0; ReqSrcA = '0; ReqSrcB = '0;
    ReqDst = '0; ReqWF = 1'b0; LoadEn = 1'b0; LoadSel = '0; LoadData = '0; DbgSel = '0;
    tick(); tick();

    // Reset state
    check("rst_ready", ReqReady, 1'b1);
    check("rst_A", A, 16'h0);
    check("rst_B", B, 16'h0);
    check("rst_funsel", FunSel, 5'b10000);
    check("rst_wf", WF, 1'b0);
    check("rst_done_valid", DoneValid, 1'b0);
    check("rst_done_result", DoneResult, 16'h0);
    check("rst_done_flags", DoneFlags, 4'h0);
    Reset = 1'b1;
    tick();

    // 0x7FFF + 0x0001 -> R3
    load_reg(3'd1, 16'h7FFF);
    load_reg(3'd2, 16'h0001);
    issue(5'b10100, 3'd1, 3'd2, 3'd3, 1'b1);
    check("s1_drive_ready", ReqReady, 1'b0);
    check("s1_drive_A", A, 16'h7FFF);
    check("s1_drive_B", B, 16'h0001);
    check("s1_drive_funsel", FunSel, 5'b10100);
    check("s1_drive_wf", WF, 1'b1);
    check("s1_drive_dv", DoneValid, 1'b0);
    tick();
    check("s1_cap_dv", DoneValid, 1'b0);
    check("s1_cap_A", A, 16'h7FFF);
    check("s1_cap_wf", WF, 1'b1);
    tick();
    check("s1_done_dv", DoneValid, 1'b1);
    check("s1_done_result", DoneResult, 16'h8000);
    check("s1_done_flags", DoneFlags, 4'b0011);
    read_reg(3'd3, rv);
    check("s1_r3", rv, 16'h8000);
    tick();
    check("s1_idle_dv", DoneValid, 1'b0);
    check("s1_idle_ready", ReqReady, 1'b1);
    check("s1_idle_wf", WF, 1'b0);
    check("s1_idle_funsel_hold", FunSel, 5'b10100);
    check("s1_idle_A_hold", A, 16'h7FFF);

    // Narrow pass of R4 -> R5, ReqReady low for 3 cycles
    load_reg(3'd4, 16'h12F0);
    issue(5'b00000, 3'd4, 3'd0, 3'd5, 1'b0);
    check("s2_rdy_c1", ReqReady, 1'b0);
    tick();
    check("s2_rdy_c2", ReqReady, 1'b0);
    tick();
    check("s2_rdy_c3", ReqReady, 1'b0);
    check("s2_done_dv", DoneValid, 1'b1);
    check("s2_done_result", DoneResult, 16'h00F0);
    tick();
    check("s2_rdy_back", ReqReady, 1'b1);
    read_reg(3'd5, rv);
    check("s2_r5", rv, 16'h00F0);

    // R6 - R7 -> R6 (destination aliases a source)
    load_reg(3'd6, 16'h0005);
    load_reg(3'd7, 16'h0003);
    issue(5'b10110, 3'd6, 3'd7, 3'd6, 1'b1);
    check("s3_result_hold", DoneResult, 16'h00F0);
    tick(); tick();
    check("s3_done_result", DoneResult, 16'h0002);
    tick();
    read_reg(3'd6, rv);
    check("s3_r6", rv, 16'h0002);

    // Load to a source in DRIVE, colliding load to Dst in CAPTURE
    issue(5'b10100, 3'd1, 3'd2, 3'd5, 1'b1);
    LoadEn = 1'b1; LoadSel = 3'd1; LoadData = 16'h0000;
    tick();
    check("s4_cap_A_stable", A, 16'h7FFF);
    LoadSel = 3'd5; LoadData = 16'hBEEF;
    tick();
    LoadEn = 1'b0;
    check("s4_done_result", DoneResult, 16'h8000);
    tick();
    read_reg(3'd5, rv);
    check("s4_r5_wb_wins", rv, 16'h8000);
    read_reg(3'd1, rv);
    check("s4_r1_loaded", rv, 16'h0000);

    // Reset during DRIVE
    issue(5'b10100, 3'd6, 3'd2, 3'd3, 1'b1);
    #2;
    Reset = 1'b0;
    #1;
    check("s5_rst_ready", ReqReady, 1'b1);
    check("s5_rst_A", A, 16'h0);
    check("s5_rst_funsel", FunSel, 5'b10000);
    check("s5_rst_wf", WF, 1'b0);
    check("s5_rst_result", DoneResult, 16'h0);
    check("s5_rst_dv", DoneValid, 1'b0);
    tick(); tick();
    for (int i = 0; i < 8; i++) begin
      read_reg(i[2:0], rv);
      check($sformatf("s5_reg%0d_zero", i), rv, 16'h0);
    end
    Reset = 1'b1;
    check("s5_ready_after_release", ReqReady, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("s5_no_done_%0d", i), DoneValid, 1'b0);
    end
    read_reg(3'd3, rv);
    check("s5_r3_no_wb", rv, 16'h0);

    // Continuous ReqValid: R3 += R1 four times
    load_reg(3'd1, 16'h0001);
    ReqFunSel = 5'b10100; ReqSrcA = 3'd3; ReqSrcB = 3'd1; ReqDst = 3'd3; ReqWF = 1'b0;
    ReqValid  = 1'b1;
    n_done    = 0;
    for (int c = 0; c < 24; c++) begin
      if (ReqValid && ReqReady) hs_cyc.push_back(c);
      tick();
      if (hs_cyc.size() == 4) ReqValid = 1'b0;
      if (DoneValid) n_done++;
    end
    ReqValid = 1'b0;
    check("s6_accept_count", hs_cyc.size(), 4);
    for (int i = 1; i < hs_cyc.size(); i++) begin
      check($sformatf("s6_gap_%0d", i), hs_cyc[i] - hs_cyc[i-1], 4);
    end
    check("s6_done_count", n_done, 4);
    read_reg(3'd3, rv);
    check("s6_r3_final", rv, 16'h0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
